// File: rtl/instr_dispatch_if.sv
// Handshake bundle between the instruction dispatcher and the fetch/execution FSMs.
interface instr_dispatch_if #(
  parameter int NUM_UNITS = 4
) ();
  logic                 run;
  logic                 fetch_start;
  logic                 fetch_done;
  logic [15:0]          ir;
  logic [NUM_UNITS-1:0] unit_start;
  logic [NUM_UNITS-1:0] unit_done;
  logic [5:0]           parameter1;
  logic [5:0]           parameter2;
  logic                 busy;
  logic                 halted;
  logic                 illegal;
  logic                 timeout_err;
  logic [15:0]          instr_count;

  modport master (
    input  run, fetch_done, ir, unit_done,
    output fetch_start, unit_start, parameter1, parameter2,
           busy, halted, illegal, timeout_err, instr_count
  );

  modport slave (
    output run, fetch_done, ir, unit_done,
    input  fetch_start, unit_start, parameter1, parameter2,
           busy, halted, illegal, timeout_err, instr_count
  );
endinterface

// File: rtl/instr_dispatch.sv
// Top-level sequencer: fetch, decode, start one execution unit, retire, halt.
// Optional watchdog on fetch/unit waits enabled by macro INSTR_DISPATCH_TIMEOUT_EN.
module instr_dispatch #(
  parameter int NUM_UNITS = 4,
  parameter int TIMEOUT   = 32,
  parameter int MAX_REG   = 4
) (
  input logic              clk,
  input logic              rst,
  instr_dispatch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_RETIRE = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [5:0] MAX_REG_C = 6'(MAX_REG);
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_HALT   = 4'hF;

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("instr_dispatch: TIMEOUT must be at least 2");
  end

  state_t               state_r;
  state_t               state_n;
  logic [3:0]           opcode_r;
  logic [5:0]           param1_r;
  logic [5:0]           param2_r;
  logic [NUM_UNITS-1:0] sel_r;
  logic [NUM_UNITS-1:0] dec_onehot_s;
  logic [NUM_UNITS-1:0] start_n_s;
  logic [NUM_UNITS-1:0] unit_start_r;
  logic                 fetch_start_r;
  logic                 busy_r;
  logic                 halted_r;
  logic                 illegal_r;
  logic                 timeout_err_r;
  logic [15:0]          count_r;
  logic                 latch_ir_s;
  logic                 set_illegal_s;
  logic                 set_timeout_s;
  logic                 timeout_hit_s;
  logic                 operands_ok_s;

`ifdef INSTR_DISPATCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt_r;

  assign timeout_hit_s = ((state_r == S_FETCH) || (state_r == S_EXEC)) &&
                         (wait_cnt_r == WAIT_W'(TIMEOUT - 1));

  // Wait counter: cleared on any state change, counts while parked in FETCH/EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (state_n != state_r) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if ((state_r == S_FETCH) || (state_r == S_EXEC)) begin
      wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  assign operands_ok_s = (param1_r <= MAX_REG_C) && (param2_r <= MAX_REG_C);

  // Opcode-to-unit one-hot decode: opcode k selects unit k-1.
  always_comb begin
    dec_onehot_s = {NUM_UNITS{1'b0}};
    for (int i = 0; i < NUM_UNITS; i++) begin
      dec_onehot_s[i] = (opcode_r == 4'(i + 1));
    end
  end

  // Next-state logic for the dispatch sequencer.
  always_comb begin
    state_n       = state_r;
    latch_ir_s    = 1'b0;
    set_illegal_s = 1'b0;
    set_timeout_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.run) state_n = S_FETCH;
        else         state_n = S_IDLE;
      end
      S_FETCH: begin
        if (bus.fetch_done) begin
          state_n    = S_DECODE;
          latch_ir_s = 1'b1;
        end else if (timeout_hit_s) begin
          state_n       = S_HALTED;
          set_timeout_s = 1'b1;
        end else begin
          state_n = S_FETCH;
        end
      end
      S_DECODE: begin
        if (opcode_r == OP_NOP) begin
          state_n = S_RETIRE;
        end else if (opcode_r == OP_HALT) begin
          state_n = S_HALTED;
        end else if ((|dec_onehot_s) && operands_ok_s) begin
          state_n = S_EXEC;
        end else begin
          state_n       = S_HALTED;
          set_illegal_s = 1'b1;
        end
      end
      S_EXEC: begin
        // Done pulses from units other than the selected one are ignored.
        if (|(bus.unit_done & sel_r)) begin
          state_n = S_RETIRE;
        end else if (timeout_hit_s) begin
          state_n       = S_HALTED;
          set_timeout_s = 1'b1;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_RETIRE: begin
        if (bus.run) state_n = S_FETCH;
        else         state_n = S_IDLE;
      end
      S_HALTED: state_n = S_HALTED;
      default:  state_n = S_IDLE;
    endcase
  end

  // Unit start vector for the coming cycle; sel_r is not yet valid on the DECODE edge.
  always_comb begin
    start_n_s = {NUM_UNITS{1'b0}};
    if (state_n == S_EXEC) begin
      if (state_r == S_DECODE) start_n_s = dec_onehot_s;
      else                     start_n_s = sel_r;
    end else begin
      start_n_s = {NUM_UNITS{1'b0}};
    end
  end

  // State, latched instruction fields, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      opcode_r      <= 4'h0;
      param1_r      <= 6'd0;
      param2_r      <= 6'd0;
      sel_r         <= {NUM_UNITS{1'b0}};
      count_r       <= 16'd0;
      illegal_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      fetch_start_r <= 1'b0;
      unit_start_r  <= {NUM_UNITS{1'b0}};
      busy_r        <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r <= state_n;
      if (latch_ir_s) begin
        opcode_r <= bus.ir[15:12];
        param1_r <= bus.ir[11:6];
        param2_r <= bus.ir[5:0];
      end
      if (state_r == S_DECODE) sel_r <= dec_onehot_s;
      if (state_r == S_RETIRE) count_r <= count_r + 16'd1;
      if (set_illegal_s) illegal_r <= 1'b1;
      if (set_timeout_s) timeout_err_r <= 1'b1;
      fetch_start_r <= (state_n == S_FETCH);
      unit_start_r  <= start_n_s;
      busy_r        <= (state_n != S_IDLE) && (state_n != S_HALTED);
      halted_r      <= (state_n == S_HALTED);
    end
  end

  assign bus.fetch_start = fetch_start_r;
  assign bus.unit_start  = unit_start_r;
  assign bus.parameter1  = param1_r;
  assign bus.parameter2  = param2_r;
  assign bus.busy        = busy_r;
  assign bus.halted      = halted_r;
  assign bus.illegal     = illegal_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.instr_count = count_r;

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed self-checking bench for instr_dispatch (inputs driven and outputs sampled on negedge).
module tb_instr_dispatch;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   multi_start = 0;

  always #5 clk = ~clk;

  instr_dispatch_if #(.NUM_UNITS(4)) bus ();

  instr_dispatch #(.NUM_UNITS(4), .TIMEOUT(8), .MAX_REG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Count any cycle with more than one unit start active.
  always @(negedge clk) begin
    if (!$onehot0(bus.unit_start)) multi_start++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {27'd0, bus.fetch_start, bus.unit_start, bus.busy, bus.halted, bus.illegal,
            bus.timeout_err, bus.parameter1, bus.parameter2, bus.instr_count};
  endfunction

  // Present one instruction for a single edge from FETCH; ends in DECODE.
  task automatic fetch(input logic [15:0] instr);
    bus.ir = instr;
    bus.fetch_done = 1'b1;
    tick();
    bus.fetch_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.run = 1'b0;
    bus.fetch_done = 1'b0;
    bus.ir = 16'h0000;
    bus.unit_done = 4'b0000;
    @(negedge clk);
    tick();
    check("reset_outputs", all_out(), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_no_run", {bus.fetch_start, bus.busy}, 64'd0);

    // LOAD r1 -> r3
    bus.run = 1'b1;
    tick();
    check("fetch_start_on_run", {bus.fetch_start, bus.busy}, 64'b11);
    fetch(16'h1043);
    check("decode_no_start", {bus.fetch_start, bus.unit_start}, 64'd0);
    check("load_params", {bus.parameter1, bus.parameter2}, {52'd0, 6'd1, 6'd3});
    tick();
    check("load_unit_start", bus.unit_start, 64'b0001);
    bus.unit_done = 4'b0001;
    tick();
    bus.unit_done = 4'b0000;
    check("retire_start_drop", {bus.unit_start, bus.instr_count}, 64'd0);
    tick();
    check("load_retired", {bus.fetch_start, bus.instr_count}, {47'd0, 1'b1, 16'd1});

    // NOP, MOVE, ADD
    fetch(16'h0000);
    tick();
    check("nop_no_start", bus.unit_start, 64'd0);
    tick();
    check("nop_retired", bus.instr_count, 64'd2);
    fetch(16'h3042);
    tick();
    check("move_unit_start", bus.unit_start, 64'b0100);
    check("move_params", {bus.parameter1, bus.parameter2}, {52'd0, 6'd1, 6'd2});
    bus.unit_done = 4'b0100;
    tick();
    bus.unit_done = 4'b0000;
    tick();
    check("move_retired", bus.instr_count, 64'd3);
    fetch(16'h4081);
    tick();
    check("add_unit_start", bus.unit_start, 64'b1000);
    bus.unit_done = 4'b0001;
    tick();
    check("ignore_done0", bus.unit_start, 64'b1000);
    bus.unit_done = 4'b0100;
    tick();
    check("ignore_done2", bus.unit_start, 64'b1000);
    bus.unit_done = 4'b1000;
    tick();
    bus.unit_done = 4'b0000;
    check("add_retire", bus.unit_start, 64'd0);
    tick();
    check("add_retired", bus.instr_count, 64'd4);

    // Reset in the middle of EXEC
    fetch(16'h1043);
    tick();
    check("exec_before_rst", bus.unit_start, 64'b0001);
    do_reset();
    check("rst_mid_exec", all_out(), 64'd0);

    // HALT is not counted
    tick();
    check("run_after_rst", bus.fetch_start, 64'd1);
    fetch(16'h0000);
    tick();
    tick();
    check("nop_count1", bus.instr_count, 64'd1);
    fetch(16'hF000);
    tick();
    check("halt_state", {bus.halted, bus.busy, bus.illegal, bus.fetch_start}, 64'b1000);
    check("halt_count", bus.instr_count, 64'd1);
    do_reset();

    // STORE with p1=5 is illegal; HALTED ignores further fetch_done
    tick();
    fetch(16'h2145);
    tick();
    check("illegal_p1", {bus.illegal, bus.halted, bus.unit_start}, {58'd0, 1'b1, 1'b1, 4'b0000});
    bus.ir = 16'h1043;
    bus.fetch_done = 1'b1;
    tick();
    tick();
    tick();
    bus.fetch_done = 1'b0;
    check("halted_sticky", {bus.halted, bus.fetch_start, bus.unit_start, bus.parameter1},
          {52'd0, 1'b1, 1'b0, 4'b0000, 6'd5});
    do_reset();
    check("illegal_cleared", bus.illegal, 64'd0);

    // Unknown opcode and out-of-range destination
    tick();
    fetch(16'h5000);
    tick();
    check("illegal_opcode", {bus.illegal, bus.halted}, 64'b11);
    do_reset();
    tick();
    fetch(16'h4045);
    tick();
    check("illegal_p2", {bus.illegal, bus.halted, bus.unit_start}, {58'd0, 2'b11, 4'b0000});
    do_reset();

    // Operands at MAX_REG are legal
    tick();
    fetch(16'h1104);
    tick();
    check("max_reg_legal", {bus.illegal, bus.unit_start}, {59'd0, 1'b0, 4'b0001});
    // run dropped during EXEC: instruction completes, then IDLE
    bus.run = 1'b0;
    bus.unit_done = 4'b0001;
    tick();
    bus.unit_done = 4'b0000;
    tick();
    check("stop_at_retire", {bus.fetch_start, bus.busy, bus.instr_count}, 64'd1);
    tick();
    check("idle_stays", {bus.fetch_start, bus.busy}, 64'd0);

    // Counter wrap from 16'hFFFF
    bus.run = 1'b1;
    tick();
    force dut.count_r = 16'hFFFF;
    tick();
    release dut.count_r;
    tick();
    check("preload_count", bus.instr_count, 64'hFFFF);
    fetch(16'h0000);
    tick();
    tick();
    check("count_wrap", bus.instr_count, 64'd0);

    // Never return unit_done
    fetch(16'h4081);
    tick();
    check("wait_exec", bus.unit_start, 64'b1000);
`ifdef INSTR_DISPATCH_TIMEOUT_EN
    repeat (7) tick();
    check("pre_timeout", {bus.timeout_err, bus.halted, bus.unit_start}, 64'b001000);
    tick();
    check("timeout_halt", {bus.timeout_err, bus.halted, bus.unit_start, bus.busy}, 64'b1100000);
`else
    repeat (100) tick();
    check("no_timeout", {bus.timeout_err, bus.halted, bus.unit_start, bus.busy}, 64'b0010001);
`endif

    check("single_unit_start", 64'(multi_start), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
